// File: rtl/cmn_reg_slice_forward.sv
// ---------------------------------------------------------------------------
// cmn_reg_slice_forward
//
// Forward register slice made of STAGES chained stages. Valid and payload
// come from flops; ready is combinational from m_rdy back to s_rdy. There is
// no combinational path from s_vld to m_vld. An empty stage always accepts,
// so bubbles collapse and a stalled pipe fills completely before s_rdy drops.
//
// Parameters:
//   PLD_TYPE  payload type (width $bits(PLD_TYPE))
//   STAGES    number of forward stages, 1..8
//   CNT_W     width of the occupancy count
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active-high
//   flush    synchronous flush, empties every stage at the next edge
//   s_vld    upstream valid
//   s_rdy    upstream ready (combinational, forced low in reset and flush)
//   s_pld    upstream payload
//   m_vld    downstream valid (registered)
//   m_rdy    downstream ready
//   m_pld    downstream payload (registered)
//   occ_cnt  number of occupied stages (registered)
//   idle     all stages empty
// ---------------------------------------------------------------------------
module cmn_reg_slice_forward #(
  parameter type PLD_TYPE = logic,
  parameter int  STAGES   = 1,
  parameter int  CNT_W    = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_vld,
  output logic             s_rdy,
  input  PLD_TYPE          s_pld,
  output logic             m_vld,
  input  logic             m_rdy,
  output PLD_TYPE          m_pld,
  output logic [CNT_W-1:0] occ_cnt,
  output logic             idle
);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_in;
  logic [STAGES-1:0] vld_nxt;
  logic [STAGES-1:0] rdy;
  PLD_TYPE           pld_q  [STAGES];
  PLD_TYPE           pld_in [STAGES];

  function automatic logic [CNT_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // A stage can take new data if it is empty or everything downstream of it
  // moves this cycle. Built with a running variable so the chain is a plain
  // ripple from m_rdy toward stage 0.
  always_comb begin
    logic r;
    r   = m_rdy;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r      = ~vld_q[i] | r;
      rdy[i] = r;
    end
  end

  always_comb begin
    vld_in    = '0;
    vld_in[0] = s_vld;
    pld_in[0] = s_pld;
    for (int i = 1; i < STAGES; i++) begin
      vld_in[i] = vld_q[i-1];
      pld_in[i] = pld_q[i-1];
    end
  end

  always_comb begin
    vld_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        vld_nxt[i] = 1'b0;
      end else if (rdy[i]) begin
        vld_nxt[i] = vld_in[i];
      end else begin
        vld_nxt[i] = vld_q[i];
      end
    end
  end

  // ---- stage registers: valid bits and occupancy ----
  // occ_cnt is the popcount of the next valid vector so it lines up with
  // vld_q in every cycle without an extra adder on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      occ_cnt <= '0;
    end else begin
      vld_q   <= vld_nxt;
      occ_cnt <= popcount(vld_nxt);
    end
  end

  // ---- stage registers: payload ----
  // Payload only loads with a valid beat, so bubbles and flushes leave it
  // untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pld_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i] && !flush && vld_in[i]) begin
          pld_q[i] <= pld_in[i];
        end
      end
    end
  end

  assign m_vld = vld_q[STAGES-1];
  assign m_pld = pld_q[STAGES-1];
  assign s_rdy = rdy[0] & ~flush & ~rst;
  assign idle  = (occ_cnt == '0);

endmodule

// File: tb/tb_cmn_reg_slice_forward.sv
// ---------------------------------------------------------------------------
// tb_cmn_reg_slice_forward
//
// Five instances with STAGES = 1, 2, 3, 4, 8 and an 8-bit payload share one
// clock and reset. Directed scenarios use per-cycle expectation tables; the
// random scenario keeps a FIFO of accepted payloads as its reference.
// ---------------------------------------------------------------------------
module tb_cmn_reg_slice_forward;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush [N];
  logic       s_vld [N];
  logic       s_rdy [N];
  logic [7:0] s_pld [N];
  logic       m_vld [N];
  logic       m_rdy [N];
  logic [7:0] m_pld [N];
  logic [3:0] occ   [N];
  logic       idle  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 8;
    cmn_reg_slice_forward #(
      .PLD_TYPE (logic [7:0]),
      .STAGES   (S),
      .CNT_W    (4)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush[g]),
      .s_vld   (s_vld[g]),
      .s_rdy   (s_rdy[g]),
      .s_pld   (s_pld[g]),
      .m_vld   (m_vld[g]),
      .m_rdy   (m_rdy[g]),
      .m_pld   (m_pld[g]),
      .occ_cnt (occ[g]),
      .idle    (idle[g])
    );
  end

  function automatic int stages_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  task automatic idle_all();
    for (int g = 0; g < N; g++) begin
      flush[g] = 1'b0;
      s_vld[g] = 1'b0;
      s_pld[g] = 8'h00;
      m_rdy[g] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset values of every instance, and s_rdy released after reset.
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    for (int g = 0; g < N; g++) begin
      checks++; if (m_vld[g] !== 1'b0) begin errors++; $display("FAIL reset_m_vld[%0d]: got %b expected 0", g, m_vld[g]); end
      checks++; if (occ[g] !== 4'd0) begin errors++; $display("FAIL reset_occ[%0d]: got %0d expected 0", g, occ[g]); end
      checks++; if (idle[g] !== 1'b1) begin errors++; $display("FAIL reset_idle[%0d]: got %b expected 1", g, idle[g]); end
      checks++; if (s_rdy[g] !== 1'b0) begin errors++; $display("FAIL reset_s_rdy[%0d]: got %b expected 0", g, s_rdy[g]); end
      checks++; if (m_pld[g] !== 8'h00) begin errors++; $display("FAIL reset_m_pld[%0d]: got %0h expected 00", g, m_pld[g]); end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      checks++; if (s_rdy[g] !== 1'b1) begin errors++; $display("FAIL post_reset_s_rdy[%0d]: got %b expected 1", g, s_rdy[g]); end
    end
    tick();
  endtask

  // STAGES=2, m_rdy=1: three back-to-back pushes appear two cycles later.
  task automatic test_latency();
    int         sel = 1;
    logic [5:0] vin, emv;
    logic [7:0] pin  [6];
    logic [7:0] emp  [6];
    logic [3:0] eocc [6];
    vin  = 6'b000111;
    emv  = 6'b011100;
    pin  = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    emp  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    eocc = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0};
    m_rdy[sel] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_vld[sel] = vin[c];
      s_pld[sel] = pin[c];
      @(negedge clk);
      checks++; if (s_rdy[sel] !== 1'b1) begin errors++; $display("FAIL latency_s_rdy c%0d: got %b expected 1", c, s_rdy[sel]); end
      checks++; if (m_vld[sel] !== emv[c]) begin errors++; $display("FAIL latency_m_vld c%0d: got %b expected %b", c, m_vld[sel], emv[c]); end
      if (emv[c]) begin
        checks++; if (m_pld[sel] !== emp[c]) begin errors++; $display("FAIL latency_m_pld c%0d: got %0h expected %0h", c, m_pld[sel], emp[c]); end
      end
      checks++; if (occ[sel] !== eocc[c]) begin errors++; $display("FAIL latency_occ c%0d: got %0d expected %0d", c, occ[sel], eocc[c]); end
      tick();
    end
    idle_all();
  endtask

  // STAGES=2, m_rdy=0: pipe fills, holds A0 stable, then drains in order.
  task automatic test_stall();
    int         sel = 1;
    logic [8:0] vin, mr, esr, emv;
    logic [7:0] pin  [9];
    logic [7:0] emp  [9];
    logic [3:0] eocc [9];
    vin  = 9'b000111111;
    mr   = 9'b111100000;
    esr  = 9'b111100011;
    emv  = 9'b011111100;
    pin  = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'h00, 8'h00, 8'h00};
    emp  = '{8'h00, 8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'h00};
    eocc = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    for (int c = 0; c < 9; c++) begin
      s_vld[sel] = vin[c];
      s_pld[sel] = pin[c];
      m_rdy[sel] = mr[c];
      @(negedge clk);
      checks++; if (s_rdy[sel] !== esr[c]) begin errors++; $display("FAIL stall_s_rdy c%0d: got %b expected %b", c, s_rdy[sel], esr[c]); end
      checks++; if (m_vld[sel] !== emv[c]) begin errors++; $display("FAIL stall_m_vld c%0d: got %b expected %b", c, m_vld[sel], emv[c]); end
      if (emv[c]) begin
        checks++; if (m_pld[sel] !== emp[c]) begin errors++; $display("FAIL stall_m_pld c%0d: got %0h expected %0h", c, m_pld[sel], emp[c]); end
      end
      checks++; if (occ[sel] !== eocc[c]) begin errors++; $display("FAIL stall_occ c%0d: got %0d expected %0d", c, occ[sel], eocc[c]); end
      tick();
    end
    idle_all();
  endtask

  // STAGES=3: full pipe with push and pop in the same cycle keeps occupancy.
  task automatic test_full_push_pop();
    int         sel = 2;
    logic [9:0] vin, mr, esr, emv;
    logic [7:0] pin  [10];
    logic [7:0] emp  [10];
    logic [3:0] eocc [10];
    vin  = 10'b0000010111;
    mr   = 10'b1111010000;
    esr  = 10'b1111010111;
    emv  = 10'b0111111000;
    pin  = '{8'hB0, 8'hB1, 8'hB2, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    emp  = '{8'h00, 8'h00, 8'h00, 8'hB0, 8'hB0, 8'hB1, 8'hB1, 8'hB2, 8'hB3, 8'h00};
    eocc = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int c = 0; c < 10; c++) begin
      s_vld[sel] = vin[c];
      s_pld[sel] = pin[c];
      m_rdy[sel] = mr[c];
      @(negedge clk);
      checks++; if (s_rdy[sel] !== esr[c]) begin errors++; $display("FAIL full_s_rdy c%0d: got %b expected %b", c, s_rdy[sel], esr[c]); end
      checks++; if (m_vld[sel] !== emv[c]) begin errors++; $display("FAIL full_m_vld c%0d: got %b expected %b", c, m_vld[sel], emv[c]); end
      if (emv[c]) begin
        checks++; if (m_pld[sel] !== emp[c]) begin errors++; $display("FAIL full_m_pld c%0d: got %0h expected %0h", c, m_pld[sel], emp[c]); end
      end
      checks++; if (occ[sel] !== eocc[c]) begin errors++; $display("FAIL full_occ c%0d: got %0d expected %0d", c, occ[sel], eocc[c]); end
      tick();
    end
    idle_all();
  endtask

  // STAGES=3: flush with two entries resident, then a fresh push of 0x5A.
  task automatic test_flush();
    int         sel = 2;
    logic [8:0] vin, fl, mr, esr, emv;
    logic [7:0] pin  [9];
    logic [7:0] emp  [9];
    logic [3:0] eocc [9];
    vin  = 9'b000010111;
    fl   = 9'b000000100;
    mr   = 9'b111110000;
    esr  = 9'b111111011;
    emv  = 9'b010000000;
    pin  = '{8'hC0, 8'hC1, 8'hEE, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    emp  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00};
    eocc = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
    for (int c = 0; c < 9; c++) begin
      s_vld[sel] = vin[c];
      s_pld[sel] = pin[c];
      m_rdy[sel] = mr[c];
      flush[sel] = fl[c];
      @(negedge clk);
      checks++; if (s_rdy[sel] !== esr[c]) begin errors++; $display("FAIL flush_s_rdy c%0d: got %b expected %b", c, s_rdy[sel], esr[c]); end
      checks++; if (m_vld[sel] !== emv[c]) begin errors++; $display("FAIL flush_m_vld c%0d: got %b expected %b", c, m_vld[sel], emv[c]); end
      if (emv[c]) begin
        checks++; if (m_pld[sel] !== emp[c]) begin errors++; $display("FAIL flush_m_pld c%0d: got %0h expected %0h", c, m_pld[sel], emp[c]); end
      end
      checks++; if (occ[sel] !== eocc[c]) begin errors++; $display("FAIL flush_occ c%0d: got %0d expected %0d", c, occ[sel], eocc[c]); end
      checks++; if (idle[sel] !== (eocc[c] == 4'd0)) begin errors++; $display("FAIL flush_idle c%0d: got %b expected %b", c, idle[sel], (eocc[c] == 4'd0)); end
      tick();
    end
    idle_all();
  endtask

  // Random traffic against a FIFO reference; ends with a bounded drain.
  task automatic test_random(input int sel, input int ncyc);
    logic [7:0] q[$];
    int         s;
    int         recv;
    logic       exp_rdy, down, draining, stall_prev;
    logic [7:0] pld_prev;
    s          = stages_of(sel);
    recv       = 0;
    stall_prev = 1'b0;
    pld_prev   = 8'h00;
    for (int c = 0; c < ncyc + 4 * s + 8; c++) begin
      draining   = (c >= ncyc);
      s_vld[sel] = draining ? 1'b0 : 1'($urandom_range(0, 1));
      s_pld[sel] = 8'($urandom);
      m_rdy[sel] = draining ? 1'b1 : 1'($urandom_range(0, 1));
      flush[sel] = draining ? 1'b0 : ($urandom_range(0, 99) == 0);
      @(negedge clk);
      exp_rdy = ((q.size() < s) || m_rdy[sel]) && !flush[sel];
      checks++; if (s_rdy[sel] !== exp_rdy) begin errors++; $display("FAIL rand%0d_s_rdy c%0d: got %b expected %b", s, c, s_rdy[sel], exp_rdy); end
      checks++; if (occ[sel] !== 4'(q.size())) begin errors++; $display("FAIL rand%0d_occ c%0d: got %0d expected %0d", s, c, occ[sel], q.size()); end
      checks++; if (idle[sel] !== (q.size() == 0)) begin errors++; $display("FAIL rand%0d_idle c%0d: got %b expected %b", s, c, idle[sel], (q.size() == 0)); end
      if (stall_prev) begin
        checks++;
        if (m_vld[sel] !== 1'b1 || m_pld[sel] !== pld_prev) begin
          errors++; $display("FAIL rand%0d_stall_hold c%0d: got vld %b pld %0h expected vld 1 pld %0h", s, c, m_vld[sel], m_pld[sel], pld_prev);
        end
      end
      down = 1'b0;
      if (m_vld[sel] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand%0d_spurious c%0d: got m_vld 1 pld %0h expected empty pipe", s, c, m_pld[sel]);
        end else begin
          down = m_rdy[sel];
          if (m_pld[sel] !== q[0]) begin
            errors++; $display("FAIL rand%0d_order c%0d: got %0h expected %0h", s, c, m_pld[sel], q[0]);
          end
        end
      end
      stall_prev = m_vld[sel] && !m_rdy[sel] && !flush[sel];
      pld_prev   = m_pld[sel];
      if (down) begin
        void'(q.pop_front());
        recv++;
      end
      if (flush[sel]) begin
        q.delete();
      end else if (s_vld[sel] && exp_rdy) begin
        q.push_back(s_pld[sel]);
      end
      tick();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand%0d_drain: got %0d entries left expected 0", s, q.size()); end
    checks++; if (recv < ncyc / 8) begin errors++; $display("FAIL rand%0d_throughput: got %0d transfers expected at least %0d", s, recv, ncyc / 8); end
    idle_all();
  endtask

  // STAGES=4: asynchronous reset with three entries resident.
  task automatic test_reset_midstream();
    int sel = 3;
    m_rdy[sel] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_vld[sel] = (c < 3);
      s_pld[sel] = 8'hD0 + 8'(c);
      tick();
    end
    @(negedge clk);
    checks++; if (m_vld[sel] !== 1'b1) begin errors++; $display("FAIL mid_pre_m_vld: got %b expected 1", m_vld[sel]); end
    checks++; if (occ[sel] !== 4'd3) begin errors++; $display("FAIL mid_pre_occ: got %0d expected 3", occ[sel]); end
    tick();
    s_vld[sel] = 1'b1;
    s_pld[sel] = 8'hDD;
    #2 rst = 1'b1;
    #1;
    checks++; if (m_vld[sel] !== 1'b0) begin errors++; $display("FAIL mid_rst_m_vld: got %b expected 0", m_vld[sel]); end
    checks++; if (occ[sel] !== 4'd0) begin errors++; $display("FAIL mid_rst_occ: got %0d expected 0", occ[sel]); end
    checks++; if (idle[sel] !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b expected 1", idle[sel]); end
    checks++; if (s_rdy[sel] !== 1'b0) begin errors++; $display("FAIL mid_rst_s_rdy: got %b expected 0", s_rdy[sel]); end
    checks++; if (m_pld[sel] !== 8'h00) begin errors++; $display("FAIL mid_rst_m_pld: got %0h expected 00", m_pld[sel]); end
    @(negedge clk);
    checks++; if (s_rdy[sel] !== 1'b0) begin errors++; $display("FAIL mid_rst_hold_s_rdy: got %b expected 0", s_rdy[sel]); end
    @(posedge clk);
    #1 rst = 1'b0;
    s_vld[sel] = 1'b0;
    m_rdy[sel] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (m_vld[sel] !== 1'b0) begin errors++; $display("FAIL mid_stale c%0d: got m_vld %b pld %0h expected 0", c, m_vld[sel], m_pld[sel]); end
      checks++; if (s_rdy[sel] !== 1'b1) begin errors++; $display("FAIL mid_after_s_rdy c%0d: got %b expected 1", c, s_rdy[sel]); end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      s_vld[sel] = (c == 0);
      s_pld[sel] = 8'hE5;
      @(negedge clk);
      checks++; if (m_vld[sel] !== (c == 4)) begin errors++; $display("FAIL mid_repush_m_vld c%0d: got %b expected %b", c, m_vld[sel], (c == 4)); end
      if (c == 4) begin
        checks++; if (m_pld[sel] !== 8'hE5) begin errors++; $display("FAIL mid_repush_m_pld: got %0h expected e5", m_pld[sel]); end
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    test_reset();
    test_latency();
    test_stall();
    test_full_push_pop();
    test_flush();
    test_random(0, 8000);
    test_random(3, 8000);
    test_random(4, 8000);
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
